// File: rtl/pwm_duty_arbiter_if.sv
// Purpose : bundle of requester-side signals between the control requesters and the duty arbiter.
// Latency : n/a (wires only).
// Backpres: busy/en tell requesters when no grant can be issued; req is held until grant.
// Ports   : req/req_data from requesters; grant/duty/en/busy back from the arbiter.
interface pwm_duty_arbiter_if #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [N-1:0]         duty;
  logic                 en;
  logic                 busy;

  modport master (output req, req_data, input grant, duty, en, busy);
  modport slave  (input req, req_data, output grant, duty, en, busy);
endinterface

// File: rtl/pwm_duty_arbiter.sv
// Purpose : round-robin arbiter sharing one PWM duty register among NUM_REQ requesters.
// Latency : req sampled at edge T -> grant/duty valid in cycle T+1; en/busy high for SETTLE_CYCLES after a change.
// Backpres: while settling, req is ignored (busy=1); requesters hold req/req_data until their grant.
// Ports   : clk, reset_n (async, active-low); bus = slave side of pwm_duty_arbiter_if.
module pwm_duty_arbiter #(
  parameter int N             = 8,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  pwm_duty_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [PW-1:0]      r_last, w_last_nxt;
  logic [N-1:0]       r_duty, w_duty_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_en;
  logic               r_busy;

  logic [N-1:0]       w_data [NUM_REQ];
  logic               w_win_vld;
  logic [PW-1:0]      w_win_idx;

  // Search starts one past the last winner and wraps, so every requester
  // waits at most NUM_REQ-1 grants.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [PW-1:0]      last);
    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data[i] = bus.req_data[i*N +: N];
    end
  end

  always_comb begin
    {w_win_vld, w_win_idx} = rr_pick(bus.req, r_last);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_duty_nxt  = r_duty;
    w_grant_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_grant_nxt[w_win_idx] = 1'b1;
          w_last_nxt             = w_win_idx;
          // A same-value update is acknowledged but opens no settle window.
          if (w_data[w_win_idx] != r_duty) begin
            w_duty_nxt  = w_data[w_win_idx];
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= PW'(NUM_REQ - 1);
      r_duty  <= '0;
      r_grant <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_duty  <= w_duty_nxt;
      r_grant <= w_grant_nxt;
      // en/busy are flopped copies of "next state is SETTLE" so they line up
      // with the state register without a combinational decode on the outputs.
      r_en    <= (w_state_nxt == ST_SETTLE);
      r_busy  <= (w_state_nxt == ST_SETTLE);
    end
  end

  assign bus.grant = r_grant;
  assign bus.duty  = r_duty;
  assign bus.en    = r_en;
  assign bus.busy  = r_busy;

endmodule
